bcd_conv_ctrl: RTL

Upstream sequencer for the serial 8-bit double-dabble stage. It accepts an 8-bit binary operand over a valid/ready handshake and holds the dabble stage cleared while idle. It then streams the operand into the stage MSB-first, one bit per clock, and captures the resulting 10-bit BCD word. The captured word is presented with a one-cycle valid strobe.

---
 rtl/bcd_conv_ctrl.sv | 115 +++++++++++
 1 files changed

// File: rtl/bcd_conv_ctrl.sv
// Sequencer for a serial 8-bit double-dabble stage: accepts an operand, streams it MSB-first,
// captures the 10-bit BCD result. Optional self-check enabled by defining BCD_CONV_CHECK_EN.
module bcd_conv_ctrl (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic       ser_bit_o,
  output logic       ser_rst_n_o,
  input  logic [9:0] bcd_i,
  output logic [9:0] bcd_o,
  output logic       bcd_valid_o,
  output logic       busy_o,
  output logic       err_o
);

  typedef enum logic [1:0] {StIdle, StShift, StCapture} state_e;

  state_e     state;
  logic [7:0] operand;
  logic [2:0] cnt;
  logic       ready;
  logic       ser_bit;
  logic       ser_rst_n;
  logic [9:0] bcd;
  logic       bcd_valid;
  logic       mismatch;

`ifdef BCD_CONV_CHECK_EN
  logic       err;
  logic [9:0] ref_bcd;

  function automatic logic [9:0] to_bcd(input logic [7:0] bin);
    logic [11:0] s;
    s = '0;
    for (int i = 7; i >= 0; i--) begin
      if (s[3:0] >= 4'd5) s[3:0] = s[3:0] + 4'd3;
      if (s[7:4] >= 4'd5) s[7:4] = s[7:4] + 4'd3;
      s = {s[10:0], bin[i]};
    end
    return s[9:0];
  endfunction

  assign ref_bcd  = to_bcd(operand);
  assign mismatch = (state == StCapture) && (bcd_i != ref_bcd);
  assign err_o    = err;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      err <= 1'b0;
    end else begin
      err <= mismatch;
    end
  end
`else
  assign mismatch = 1'b0;
  assign err_o    = mismatch;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state     <= StIdle;
      operand   <= '0;
      cnt       <= '0;
      ready     <= 1'b0;
      ser_bit   <= 1'b0;
      ser_rst_n <= 1'b0;
      bcd       <= '0;
      bcd_valid <= 1'b0;
    end else begin
      bcd_valid <= 1'b0;
      unique case (state)
        StIdle: begin
          if (valid_i && ready) begin
            operand   <= data_i;
            cnt       <= '0;
            ready     <= 1'b0;
            ser_rst_n <= 1'b1;
            ser_bit   <= data_i[7];
            state     <= StShift;
          end else begin
            ready <= 1'b1;
          end
        end
        StShift: begin
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            // Stage must be held clear outside SHIFT; it has no enable.
            ser_rst_n <= 1'b0;
            ser_bit   <= 1'b0;
            state     <= StCapture;
          end else begin
            ser_bit <= operand[3'd6 - cnt];
          end
        end
        StCapture: begin
          bcd       <= bcd_i;
          bcd_valid <= 1'b1;
          ready     <= 1'b1;
          state     <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign ready_o     = ready;
  assign busy_o      = (state != StIdle);
  assign ser_bit_o   = ser_bit;
  assign ser_rst_n_o = ser_rst_n;
  assign bcd_o       = bcd;
  assign bcd_valid_o = bcd_valid;

endmodule
